// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with mid-bit majority vote, parity and stop checks.
// Optional break detection (rx_break port, BREAK state) is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_os #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 rx_break
`endif
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_LAST  = TW'(DIV - 1);
  localparam logic [SW-1:0] SC_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SC_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_RX_BREAK_DETECT_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_DONE, S_BREAK
  } state_t;

  state_t               state;
  logic                 rx_m, rx_s, rx_q;
  logic [TW-1:0]        tcnt;
  logic [SW-1:0]        sc;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, perr, ferr, all_zero;

  logic tick, vote, vote_now, sc_wrap, fall;
  assign tick     = (tcnt == T_LAST);
  assign vote     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign vote_now = tick && (sc == SC_HI);
  assign sc_wrap  = tick && (sc == SC_LAST);
  assign fall     = rx_q & ~rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      tcnt       <= '0;
      sc         <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      par_acc    <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      all_zero   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      rx_break   <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      rx_break <= 1'b0;
`endif
      tcnt <= tick ? '0 : tcnt + 1'b1;
      if (state != S_IDLE && tick) begin
        sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
        if (sc == SC_LO)  s0 <= rx_s;
        if (sc == SC_MID) s1 <= rx_s;
      end

      case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            sc    <= '0;
            tcnt  <= '0;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (vote_now && vote) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (sc_wrap) begin
            state    <= S_DATA;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_acc  <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            all_zero <= 1'b1;
          end
        end
        S_DATA: begin
          if (vote_now) begin
            shreg   <= {vote, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ vote;
            if (vote) all_zero <= 1'b0;
          end
          if (sc_wrap) begin
            if (bit_idx == B_LAST) state <= (PARITY != 0) ? S_PAR : S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        S_PAR: begin
          if (vote_now) begin
            perr <= (PARITY == 2) ? ~(par_acc ^ vote) : (par_acc ^ vote);
            if (vote) all_zero <= 1'b0;
          end
          if (sc_wrap) state <= S_STOP;
        end
        S_STOP: begin
          // Leave at the last stop-bit vote so the next start edge has half a bit of slack.
          if (vote_now) begin
            if (!vote) ferr <= 1'b1;
            if (!stop_idx && vote) all_zero <= 1'b0;
            if (STOP_BITS == 1 || stop_idx) state <= S_DONE;
          end else if (sc_wrap) begin
            stop_idx <= 1'b1;
          end
        end
        S_DONE: begin
          rx_valid   <= 1'b1;
          rx_data    <= shreg;
          parity_err <= perr;
          frame_err  <= ferr;
`ifdef UART_RX_BREAK_DETECT_EN
          rx_break   <= all_zero;
`endif
          if (BREAK_EN && all_zero) begin
            state <= S_BREAK;
            sc    <= '0;
            tcnt  <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_BREAK: begin
          // A full bit period of idle-high must elapse before a new start is armed.
          if (!rx_s) begin
            sc   <= '0;
            tcnt <= '0;
          end else if (sc_wrap) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
